axi4_burst_subordinate: RTL and testbench

AXI4 full-protocol memory subordinate, the successor to the single-beat AXI4-lite subordinate. Supports FIXED, INCR and WRAP bursts up to 256 beats, narrow transfers and byte strobes. Memory depth and base address are parametrised, and each beat is decoded independently to return DECERR.
Sits on the subordinate side of the axi4_if fabric and is the target memory for master and interconnect benches.

---
 rtl/axi_burst_pkg.sv | 10 +
 rtl/axi_burst_addr_gen.sv | 28 ++
 rtl/axi4_burst_subordinate.sv | 164 ++++++++++++++++
 tb/tb_axi4_burst_subordinate.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: burst/response encodings, FSM states and WRAP-length rule shared by the AXI4 burst subordinate
package axi_burst_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wfsm_t;
  typedef enum logic {R_IDLE, R_DATA} rfsm_t;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts plus WRAP length legality
// Ports: i_addr current beat address, i_size/i_len/i_burst burst attributes,
//        o_next following beat address, o_wrap_ok high when i_len is a legal WRAP length.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [7:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_wrap_ok
);
  localparam logic [ADDR_W-1:0] ONE = 1;
  logic [ADDR_W-1:0] w_bytes, w_incr, w_win;
  always_comb begin
    w_bytes   = ONE << i_size;
    w_incr    = (i_addr & ~(w_bytes - ONE)) + w_bytes;
    // WRAP window is the whole burst footprint, aligned to its own size
    w_win     = w_bytes * ADDR_W'({1'b0, i_len} + 9'd1);
    o_wrap_ok = wrap_len_ok(i_len);
    o_next    = i_burst == FIXED ? i_addr
              : i_burst == WRAP  ? (i_addr & ~(w_win - ONE)) | (w_incr & (w_win - ONE))
              : w_incr;
  end
endmodule

// File: rtl/axi4_burst_subordinate.sv
// axi4_burst_subordinate: AXI4 memory subordinate with FIXED/INCR/WRAP bursts, narrow beats, strobes and per-beat decode
// Ports: ACLK clock, ARESET async active-high reset; AW*/W*/B* write address, data and response
//        channels; AR*/R* read address and data channels. One write and one read burst in flight,
//        each channel pair independent of the other.
module axi4_burst_subordinate
  import axi_burst_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_BYTES = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);
  localparam int NB = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_BYTES / NB);
  localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a >= BASE_ADDR && (a - BASE_ADDR) < ADDR_W'(MEM_BYTES);
  endfunction
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LANE_W);
  endfunction
  logic [DATA_W-1:0] r_mem [MEM_BYTES/NB];
  wfsm_t r_wstate, w_wnext;
  logic [ID_W-1:0] r_wid;
  logic [ADDR_W-1:0] r_waddr, w_wgen_next;
  logic [7:0] r_wlen, r_wcnt;
  logic [2:0] r_wsize;
  logic [1:0] r_wburst;
  logic r_wslv, r_wdec, w_wwrap_ok, w_wbad, w_wlast_beat, w_wfire;
  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
    .i_addr(r_waddr), .i_size(r_wsize), .i_len(r_wlen), .i_burst(r_wburst),
    .o_next(w_wgen_next), .o_wrap_ok(w_wwrap_ok)
  );
  assign w_wfire = WVALID && WREADY;
  assign w_wlast_beat = r_wcnt == r_wlen;
  // size or WRAP-length violations poison the whole burst, so no beat of it may touch memory
  assign w_wbad = r_wsize > MAX_SIZE || (r_wburst == WRAP && !w_wwrap_ok);
  assign BID = r_wid;
  assign BRESP = r_wdec ? DECERR : r_wslv ? SLVERR : OKAY;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wstate <= W_IDLE;
    else r_wstate <= w_wnext;
  end
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (AWVALID) w_wnext = W_DATA;
      W_DATA:  if (WVALID && w_wlast_beat) w_wnext = W_RESP;
      W_RESP:  if (BREADY) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
    AWREADY = r_wstate == W_IDLE;
    WREADY  = r_wstate == W_DATA;
    BVALID  = r_wstate == W_RESP;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wid <= '0; r_waddr <= '0; r_wlen <= '0; r_wcnt <= '0;
      r_wsize <= '0; r_wburst <= '0; r_wslv <= 1'b0; r_wdec <= 1'b0;
    end else if (AWVALID && AWREADY) begin
      r_wid <= AWID; r_waddr <= AWADDR; r_wlen <= AWLEN; r_wcnt <= '0;
      r_wsize <= AWSIZE; r_wburst <= AWBURST; r_wslv <= 1'b0; r_wdec <= 1'b0;
    end else if (w_wfire) begin
      r_waddr <= w_wgen_next;
      r_wcnt <= r_wcnt + 8'd1;
      r_wdec <= r_wdec | !in_range(r_waddr);
      r_wslv <= r_wslv | w_wbad | (WLAST != w_wlast_beat);
    end
  end
  always_ff @(posedge ACLK) begin
    if (w_wfire && in_range(r_waddr) && !w_wbad)
      for (int i = 0; i < NB; i++)
        if (WSTRB[i]) r_mem[word_idx(r_waddr)][i*8 +: 8] <= WDATA[i*8 +: 8];
  end
  rfsm_t r_rstate, w_rnext;
  logic [ID_W-1:0] r_rid;
  logic [ADDR_W-1:0] r_raddr, w_rgen_next, w_rbeat;
  logic [7:0] r_rlen, r_rcnt, w_rlen_m;
  logic [2:0] r_rsize, w_rsize_m;
  logic [1:0] r_rburst, w_rburst_m, r_rresp, w_rresp;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic r_rlast, w_ridle, w_rwrap_ok, w_rbad;
  // in R_IDLE the generator sees the incoming AR so beat 0 is judged with the same rules as later beats
  assign w_ridle = r_rstate == R_IDLE;
  assign w_rsize_m = w_ridle ? ARSIZE : r_rsize;
  assign w_rlen_m = w_ridle ? ARLEN : r_rlen;
  assign w_rburst_m = w_ridle ? ARBURST : r_rburst;
  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
    .i_addr(r_raddr), .i_size(w_rsize_m), .i_len(w_rlen_m), .i_burst(w_rburst_m),
    .o_next(w_rgen_next), .o_wrap_ok(w_rwrap_ok)
  );
  // address of the beat being fetched into the output register this cycle
  assign w_rbeat = w_ridle ? ARADDR : w_rgen_next;
  assign w_rbad = w_rsize_m > MAX_SIZE || (w_rburst_m == WRAP && !w_rwrap_ok);
  assign w_rresp = !in_range(w_rbeat) ? DECERR : w_rbad ? SLVERR : OKAY;
  assign w_rdata = in_range(w_rbeat) ? r_mem[word_idx(w_rbeat)] : '0;
  assign RID = r_rid;
  assign RDATA = r_rdata;
  assign RRESP = r_rresp;
  assign RLAST = r_rlast;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rstate <= R_IDLE;
    else r_rstate <= w_rnext;
  end
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (ARVALID) w_rnext = R_DATA;
      R_DATA:  if (RREADY && r_rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
    ARREADY = r_rstate == R_IDLE;
    RVALID  = r_rstate == R_DATA;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rid <= '0; r_raddr <= '0; r_rlen <= '0; r_rcnt <= '0; r_rsize <= '0;
      r_rburst <= '0; r_rdata <= '0; r_rresp <= '0; r_rlast <= 1'b0;
    end else if (ARVALID && ARREADY) begin
      r_rid <= ARID; r_raddr <= ARADDR; r_rlen <= ARLEN; r_rcnt <= '0; r_rsize <= ARSIZE;
      r_rburst <= ARBURST; r_rdata <= w_rdata; r_rresp <= w_rresp; r_rlast <= ARLEN == 8'd0;
    end else if (RVALID && RREADY) begin
      if (r_rlast) r_rlast <= 1'b0;
      else begin
        r_raddr <= w_rbeat; r_rcnt <= r_rcnt + 8'd1; r_rdata <= w_rdata;
        r_rresp <= w_rresp; r_rlast <= r_rcnt + 8'd1 == r_rlen;
      end
    end
  end
endmodule

// File: tb/tb_axi4_burst_subordinate.sv
// tb_axi4_burst_subordinate: randomized and directed bursts checked against a byte-array memory model
module tb_axi4_burst_subordinate;
  import axi_burst_pkg::*;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, MEM_BYTES = 4096, NB = DATA_W / 8;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [ID_W-1:0] AWID, BID, ARID, RID;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [NB-1:0] WSTRB;
  always #5 ACLK = ~ACLK;
  axi4_burst_subordinate #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR('0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  int n_chk = 0, n_err = 0;
  logic [7:0] m_mem [MEM_BYTES];
  logic [DATA_W-1:0] wd [256];
  logic [NB-1:0] ws [256];
  logic [DATA_W-1:0] last_rdata;
  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit in_rng(input logic [31:0] a);
    return a < MEM_BYTES;
  endfunction
  function automatic bit bad_burst(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    return size > 3 || (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] nb, al, win, base;
    nb = 32'd1 << size;
    al = a - a % nb;
    win = nb * (32'(len) + 32'd1);
    base = a - a % win;
    if (burst == FIXED || i == 0) return a;
    if (burst == WRAP) return base + (al - base + 32'(i) * nb) % win;
    return al + 32'(i) * nb;
  endfunction
  function automatic logic [DATA_W-1:0] m_word(input logic [31:0] a);
    logic [DATA_W-1:0] w;
    logic [31:0] b;
    b = a - a % NB;
    for (int k = 0; k < NB; k++) w[k*8 +: 8] = m_mem[b + k];
    return w;
  endfunction
  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit bad_last, input int hold_b, input bit gaps);
    bit dec, bad;
    logic [1:0] exp;
    logic [31:0] ba, b0;
    int t;
    dec = 0;
    bad = bad_burst(size, len, burst);
    @(negedge ACLK);
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
    if (!AWREADY) chk("aw_timeout", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, i, size, len, burst);
      while (gaps && $urandom_range(3) == 0) begin WVALID = 0; @(negedge ACLK); end
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == int'(len)) && !bad_last; WVALID = 1;
      t = 0;
      while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
      if (!WREADY) chk("w_timeout", WREADY, 1);
      @(negedge ACLK);
      if (!in_rng(ba)) dec = 1;
      else if (!bad) begin
        b0 = ba - ba % NB;
        for (int k = 0; k < NB; k++) if (ws[i][k]) m_mem[b0 + k] = wd[i][k*8 +: 8];
      end
    end
    WVALID = 0; WLAST = 0;
    exp = dec ? DECERR : (bad || bad_last) ? SLVERR : OKAY;
    BREADY = 0;
    t = 0;
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    chk("bvalid", BVALID, 1);
    for (int h = 0; h < hold_b; h++) begin
      chk("bhold_valid", BVALID, 1); chk("bhold_id", BID, id); chk("bhold_resp", BRESP, exp);
      @(negedge ACLK);
    end
    chk("bid", BID, id);
    chk("bresp", BRESP, exp);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    chk("b_done", BVALID, 0);
  endtask
  // mode 0: random RREADY, 1: RREADY always high, 2: hold RREADY low 5 cycles on beat 0
  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode);
    bit bad;
    int t, beats, gaps, hold;
    logic [31:0] ba;
    logic [DATA_W-1:0] ed;
    logic [1:0] er;
    bad = bad_burst(size, len, burst);
    beats = 0; gaps = 0; hold = mode == 2 ? 5 : 0;
    @(negedge ACLK);
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    if (!ARREADY) chk("ar_timeout", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 0;
    chk("r_latency", RVALID, 1);
    t = 0;
    while (beats <= int'(len) && t < 2000) begin
      ba = beat_addr(a, beats, size, len, burst);
      ed = in_rng(ba) ? m_word(ba) : '0;
      er = !in_rng(ba) ? DECERR : bad ? SLVERR : OKAY;
      if (hold > 0) begin
        RREADY = 0; hold--;
        chk("rhold_valid", RVALID, 1); chk("rhold_data", RDATA, ed);
        chk("rhold_resp", RRESP, er); chk("rhold_last", RLAST, beats == int'(len));
      end else begin
        RREADY = mode == 0 ? 1'($urandom_range(1)) : 1'b1;
        if (RVALID && RREADY) begin
          chk("rid", RID, id);
          if (er != SLVERR) chk("rdata", RDATA, ed);
          chk("rresp", RRESP, er);
          chk("rlast", RLAST, beats == int'(len));
          last_rdata = RDATA;
          beats++;
        end else if (mode == 1) gaps++;
      end
      @(negedge ACLK);
      t++;
    end
    RREADY = 0;
    if (mode == 1) chk("r_bubbles", gaps, 0);
    chk("r_beats", beats, int'(len) + 1);
    chk("r_done", RVALID, 0);
  endtask
  task automatic fill(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = full ? '1 : NB'($urandom);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [1:0] bu;
    logic [2:0] sz;
    logic [7:0] ln;
    logic [31:0] ad;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 1); chk("rst_arready", ARREADY, 1); chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0); chk("rst_rvalid", RVALID, 0); chk("rst_rlast", RLAST, 0);
    chk("rst_rdata", RDATA, 0); chk("rst_bresp", BRESP, 0); chk("rst_rresp", RRESP, 0);
    for (int p = 0; p < 2; p++) begin
      fill(256, 1);
      do_write(0, 32'(p * 2048), 255, 3, INCR, 0, 0, 0);
    end
    wd[0] = 64'h1111_2222_3333_4444; ws[0] = '1;
    do_write(1, 'h20, 0, 3, INCR, 0, 0, 1);
    do_read(1, 'h20, 0, 3, INCR, 1);
    chk("single_data", last_rdata, 64'h1111_2222_3333_4444);
    fill(4, 1);
    do_write(2, 'h100, 3, 3, INCR, 0, 0, 0);
    do_read(2, 'h100, 3, 3, INCR, 1);
    chk("incr_last_beat", last_rdata, wd[3]);
    fill(4, 1);
    do_write(3, 'h118, 3, 3, WRAP, 0, 0, 0);
    do_read(3, 'h100, 3, 3, INCR, 1);
    chk("wrap_order", last_rdata, wd[0]);
    wd[0] = '1; ws[0] = '1;
    do_write(4, 'h40, 0, 3, INCR, 0, 0, 0);
    wd[0] = 64'h0000_0000_1122_3344; ws[0] = 8'h0F;
    do_write(4, 'h40, 0, 3, INCR, 0, 0, 0);
    do_read(4, 'h40, 0, 3, INCR, 1);
    chk("strobe_merge", last_rdata, 64'hFFFF_FFFF_1122_3344);
    fill(1, 1);
    do_write(5, 'h2000, 0, 3, INCR, 0, 0, 0);
    do_read(5, 'h2000, 1, 3, INCR, 1);
    do_read(5, 'h0, 0, 3, INCR, 1);
    fill(2, 1);
    do_write(6, 'hFF8, 1, 3, INCR, 0, 0, 0);
    do_read(6, 'hFF8, 1, 3, INCR, 0);
    fill(1, 1);
    do_write(7, 'h80, 0, 4, INCR, 0, 0, 0);
    do_read(7, 'h80, 0, 3, INCR, 1);
    do_read(7, 'h80, 1, 4, INCR, 1);
    fill(3, 1);
    do_write(8, 'h100, 2, 3, WRAP, 0, 0, 0);
    do_read(8, 'h100, 3, 3, INCR, 1);
    fill(2, 1);
    do_write(9, 'h180, 1, 3, INCR, 1, 0, 0);
    do_read(9, 'h180, 1, 3, INCR, 1);
    fill(2, 0);
    do_write(10, 'h200, 1, 2, INCR, 0, 5, 0);
    do_read(10, 'h200, 2, 3, INCR, 2);
    fill(4, 1);
    fork
      do_write(11, 'h500, 3, 3, INCR, 0, 0, 0);
      do_read(12, 'h600, 3, 3, INCR, 1);
    join
    do_read(11, 'h500, 3, 3, INCR, 1);
    @(negedge ACLK);
    AWID = 13; AWADDR = 'h300; AWLEN = 3; AWSIZE = 3; AWBURST = INCR; AWVALID = 1;
    @(negedge ACLK);
    AWVALID = 0;
    wd[0] = {$urandom, $urandom};
    WDATA = wd[0]; WSTRB = '1; WLAST = 0; WVALID = 1;
    @(negedge ACLK);
    for (int k = 0; k < NB; k++) m_mem['h300 + k] = wd[0][k*8 +: 8];
    WDATA = {$urandom, $urandom};
    #2 ARESET = 1;
    #1 chk("rst_mid_wready", WREADY, 0);
    WVALID = 0;
    @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    chk("rst_mid_awready", AWREADY, 1);
    chk("rst_mid_bvalid", BVALID, 0);
    do_read(13, 'h300, 3, 3, INCR, 1);
    fill(4, 1);
    do_write(14, 'h340, 3, 3, INCR, 0, 0, 0);
    do_read(14, 'h340, 3, 3, INCR, 0);
    for (int n = 0; n < 40; n++) begin
      bu = 2'($urandom_range(2));
      sz = 3'($urandom_range(3));
      ln = bu == WRAP ? (8'd1 << $urandom_range(1, 4)) - 8'd1 : bu == INCR ? 8'($urandom_range(15)) : 8'($urandom_range(7));
      ad = 32'($urandom_range(MEM_BYTES + 63));
      fill(int'(ln) + 1, 0);
      if ($urandom_range(1) == 1) do_write(4'(n), ad, ln, sz, bu, 0, $urandom_range(2), 1);
      else do_read(4'(n), ad, ln, sz, bu, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
